axil_master: RTL and testbench
==============================

Name: axil_master

Overview:
AXI4-Lite initiator that turns single-beat local commands into AXI4-Lite write and read transactions toward an axil_slave-style responder. It issues one transaction at a time and returns response status and read data on a local response handshake. A watchdog turns a hung bus into an error response. It sits between control logic (or a CPU-side bridge) and the register-slave fabric.

Parameters:
ADDR_W, 24, AXI address width
DATA_W, 32, AXI data width; strobe width is DATA_W/8
TIMEOUT, 255, max cycles waiting on any single AXI handshake; 0 disables watchdog

Ports:
m_axi_aclk  in  1  clock; all logic on rising edge
m_axi_areset  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
cmd_prot  in  2  protection bits, copied to AWPROT/ARPROT
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  watchdog fired for this transaction
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_awaddr  out  ADDR_W  write address
m_axi_awprot  out  2  write protection
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_wdata  out  DATA_W  write data
m_axi_wstrobe  out  DATA_W/8  write strobes
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_bresp  in  2  write response
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_araddr  out  ADDR_W  read address
m_axi_arprot  out  2  read protection
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response

Behaviour:
- Reset: every valid/ready output is 0, including cmd_ready. Address, data, strobe, prot, rsp_* outputs and the watchdog are 0. State is IDLE. Reset mid-transaction abandons it immediately without waiting for handshakes.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE: cmd_ready=1. On cmd handshake, register addr/data/strb/prot/write and clear the watchdog.
  - write -> WRITE, with awvalid=1 and wvalid=1 from the next cycle.
  - read -> READ, with arvalid=1.
- WRITE: awvalid and wvalid drop independently, each in the cycle after its own handshake; the handshakes may occur in either order or the same cycle. When both are done -> WRESP with bready=1.
- WRESP: on bvalid&bready, capture bresp, bready=0 -> RESP.
- READ: on arvalid&arready, arvalid=0 -> RDATA with rready=1. rready is not asserted before the AR handshake.
- RDATA: on rvalid&rready, capture rdata and rresp, rready=0 -> RESP.
- RESP: rsp_valid=1 and outputs held stable until rsp_ready. On handshake -> IDLE with cmd_ready=1 the next cycle. cmd_ready is 0 in every state except IDLE.
- Valid/data stability: AXI valids never drop before their handshake, and payloads stay constant while valid is high.
- Minimum latency with an always-ready slave: cmd accept at cycle 0, AXI valids in cycle 1, response valid in cycle 2, rsp_valid in cycle 3.
- Watchdog:
  - Counts cycles in WRITE, WRESP, READ and RDATA, and resets on every state change.
  - When the count reaches TIMEOUT, deassert all AXI valids/readies and go to RESP with rsp_resp=2'b10, rsp_timeout=1 and rdata=0.
  - A handshake in the same cycle the count reaches TIMEOUT wins; no timeout is reported.
  - The counter is clog2(TIMEOUT+1) wide and saturates, never wrapping.
- rsp_timeout=0 and rsp_resp equals the slave response on normal completion.
- No outstanding transactions are allowed, and there is no combinational path from any AXI input to any AXI output.

Decomposition:
- Shared package axil_pkg holds:
  - state enum;
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - default ADDR_W/DATA_W.
- One natural sub-module: axil_watchdog, the saturating timeout counter with clear/enable/expired. Everything else stays flat in one FSM.

Test Plan:
- Write 0x55555555 to addr 0x4 with strb 0xF; slave ready immediately -> AW/W valid 1 cycle, rsp_valid 3 cycles after accept, rsp_resp=00, rsp_write=1.
- Read addr 0x4 after that write -> araddr=0x4, rsp_rdata=0x55555555, rsp_resp=00; rready never high before the AR handshake.
- Write 0x12345678 to 0x100 with wready delayed 5 cycles after awready -> awvalid drops after its handshake, wvalid held with stable wdata until the W handshake, then a single B handshake.
- Slave returns bresp=2'b11 and rresp=2'b10 -> propagated on rsp_resp; rsp_timeout=0.
- TIMEOUT=8 with arready never asserted -> arvalid drops after 8 cycles, rsp_resp=10, rsp_timeout=1, rsp_rdata=0; next command is accepted normally.
- Assert reset while in WRESP, and hold rsp_ready=0 for 4 cycles in RESP -> after reset all outputs are 0 and state is IDLE; while stalled in RESP, rsp outputs stay stable and cmd_ready=0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite master slice: bus widths, response codes
// and the FSM state encodings used by axil_master.
package axil_pkg;

  localparam int AXIL_ADDR_W = 24;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef logic [2:0] axil_state_t;

  localparam axil_state_t ST_IDLE  = 3'd0;
  localparam axil_state_t ST_WRITE = 3'd1;
  localparam axil_state_t ST_WRESP = 3'd2;
  localparam axil_state_t ST_READ  = 3'd3;
  localparam axil_state_t ST_RDATA = 3'd4;
  localparam axil_state_t ST_RESP  = 3'd5;

endpackage

// File: rtl/axil_watchdog.sv
// Saturating cycle counter that flags a bus handshake taking TIMEOUT cycles.
// A TIMEOUT of 0 disables the watchdog entirely.
module axil_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // Fires in the cycle whose closing edge would bring the count up to TIMEOUT.
  assign expired = (TIMEOUT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns one local command at a time into a single AXI
// write or read and returns status/data on a local response handshake.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W  = AXIL_ADDR_W,
  parameter int DATA_W  = AXIL_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  input  logic [1:0]            cmd_prot,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [1:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrobe,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [1:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  axil_state_t         state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          prot_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_done, w_done;
  logic wd_enable, wd_clear, wd_expired;
  logic timeout_now;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign rsp_hs = rsp_valid & rsp_ready;
  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  assign b_hs   = m_axi_bvalid & m_axi_bready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_hs   = m_axi_rvalid & m_axi_rready;

  // A channel counts as done once its valid has dropped or it handshakes now.
  assign aw_done = ~m_axi_awvalid | aw_hs;
  assign w_done  = ~m_axi_wvalid | w_hs;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = prot_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrobe = wstrb_q;

  // Handshakes are tested before the watchdog so a last-cycle handshake wins.
  always_comb begin
    state_next  = state;
    timeout_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_hs) state_next = cmd_write ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        if (aw_done && w_done) begin
          state_next = ST_WRESP;
        end else if (wd_expired) begin
          state_next  = ST_RESP;
          timeout_now = 1'b1;
        end
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_next = ST_RESP;
        end else if (wd_expired) begin
          state_next  = ST_RESP;
          timeout_now = 1'b1;
        end
      end
      ST_READ: begin
        if (ar_hs) begin
          state_next = ST_RDATA;
        end else if (wd_expired) begin
          state_next  = ST_RESP;
          timeout_now = 1'b1;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          state_next = ST_RESP;
        end else if (wd_expired) begin
          state_next  = ST_RESP;
          timeout_now = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_hs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wd_enable = (state == ST_WRITE) || (state == ST_WRESP) ||
                     (state == ST_READ)  || (state == ST_RDATA);
  assign wd_clear  = (state_next != state);

  axil_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (m_axi_aclk),
    .reset   (m_axi_areset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      prot_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= OKAY;
      rsp_timeout   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          cmd_ready <= ~cmd_hs;
          if (cmd_hs) begin
            addr_q        <= cmd_addr;
            prot_q        <= cmd_prot;
            wdata_q       <= cmd_wdata;
            wstrb_q       <= cmd_wstrb;
            rsp_write     <= cmd_write;
            m_axi_awvalid <= cmd_write;
            m_axi_wvalid  <= cmd_write;
            m_axi_arvalid <= ~cmd_write;
          end
        end
        ST_WRITE: begin
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs) m_axi_wvalid <= 1'b0;
          if (aw_done && w_done) m_axi_bready <= 1'b1;
        end
        ST_WRESP: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
          end
        end
        ST_READ: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (r_hs) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_timeout  <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: cmd_ready <= 1'b0;
      endcase

      // A hung handshake is abandoned: every AXI valid/ready is pulled down.
      if (timeout_now) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_resp      <= SLVERR;
        rsp_rdata     <= '0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master against a small AXI4-Lite slave model with
// per-channel ready delays, hang switches and programmable responses.
module tb_axil_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [1:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [23:0] m_axi_awaddr, m_axi_araddr;
  logic [1:0]  m_axi_awprot, m_axi_arprot, m_axi_bresp, m_axi_rresp;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrobe;

  axil_master #(
    .ADDR_W (24),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (areset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .cmd_prot     (cmd_prot),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awprot (m_axi_awprot),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrobe(m_axi_wstrobe),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp)
  );

  always #5 clk = ~clk;

  // Slave configuration, written only by the main sequence
  int         aw_delay = 0, w_delay = 0;
  bit         ar_hang = 1'b0, b_hang = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // Bus observations, written only by the monitor
  int          cyc = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs_n = 0;
  int          rready_early = 0, stab_err = 0;
  bit          aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;
  bit          pend_aw = 1'b0, pend_w = 1'b0, pend_ar = 1'b0;
  logic [23:0] aw_a = '0, ar_a = '0, pend_awa = '0, pend_ara = '0;
  logic [1:0]  aw_p = '0;
  logic [31:0] w_d = '0, pend_wd = '0;
  logic [3:0]  w_s = '0;
  logic [31:0] mem [0:255] = '{default: 32'h0};

  int n_cmp = 0, n_bad = 0;

  // Monitor: records handshakes, valid-high cycles and payload stability
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (areset) begin
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
      ar_seen <= 1'b0;
      pend_aw <= 1'b0;
      pend_w  <= 1'b0;
      pend_ar <= 1'b0;
    end else begin
      if (m_axi_awvalid) aw_hi <= aw_hi + 1;
      if (m_axi_wvalid)  w_hi  <= w_hi + 1;
      if (m_axi_arvalid) ar_hi <= ar_hi + 1;
      if (m_axi_rready && !ar_seen) rready_early <= rready_early + 1;
      if ((pend_aw && m_axi_awvalid && m_axi_awaddr != pend_awa) ||
          (pend_w  && m_axi_wvalid  && m_axi_wdata  != pend_wd)  ||
          (pend_ar && m_axi_arvalid && m_axi_araddr != pend_ara))
        stab_err <= stab_err + 1;
      pend_aw  <= m_axi_awvalid && !m_axi_awready;
      pend_w   <= m_axi_wvalid && !m_axi_wready;
      pend_ar  <= m_axi_arvalid && !m_axi_arready;
      pend_awa <= m_axi_awaddr;
      pend_wd  <= m_axi_wdata;
      pend_ara <= m_axi_araddr;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_seen <= 1'b1;
        aw_a    <= m_axi_awaddr;
        aw_p    <= m_axi_awprot;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_seen <= 1'b1;
        w_d    <= m_axi_wdata;
        w_s    <= m_axi_wstrobe;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
        b_hs_n  <= b_hs_n + 1;
        for (int i = 0; i < 4; i++)
          if (w_s[i]) mem[aw_a[9:2]][8*i +: 8] <= w_d[8*i +: 8];
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_seen <= 1'b1;
        ar_a    <= m_axi_araddr;
      end
      if (m_axi_rvalid && m_axi_rready) ar_seen <= 1'b0;
    end
  end

  // Slave driver: updates every ready/valid on the falling edge
  initial begin
    int aw_cnt, w_cnt;
    aw_cnt = 0;
    w_cnt  = 0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (m_axi_awvalid && !aw_seen) begin
        if (aw_cnt >= aw_delay) m_axi_awready = 1'b1;
        else begin m_axi_awready = 1'b0; aw_cnt++; end
      end else begin
        m_axi_awready = 1'b0;
        aw_cnt = 0;
      end
      if (m_axi_wvalid && !w_seen) begin
        if (w_cnt >= w_delay) m_axi_wready = 1'b1;
        else begin m_axi_wready = 1'b0; w_cnt++; end
      end else begin
        m_axi_wready = 1'b0;
        w_cnt = 0;
      end
      m_axi_arready = m_axi_arvalid && !ar_seen && !ar_hang;
      m_axi_bvalid  = aw_seen && w_seen && !b_hang;
      m_axi_bresp   = bresp_cfg;
      m_axi_rvalid  = ar_seen;
      m_axi_rdata   = ar_seen ? mem[ar_a[9:2]] : 32'h0;
      m_axi_rresp   = rresp_cfg;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [23:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] prot, output int acc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    cmd_prot  = prot;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept", 64'(cmd_ready), 64'd1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runTxn(input string tag, input logic wr, input logic [23:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [1:0] prot,
                        input int stall, input int exp_lat, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_resp, input logic exp_to);
    int acc, n;
    applyStimulus(wr, addr, data, strb, prot, acc);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_latency"}, 64'(cyc - acc), 64'(exp_lat));
    checkOutput({tag, "_wr_to_resp_rdata"}, {rsp_write, rsp_timeout, rsp_resp, rsp_rdata},
                {wr, exp_to, exp_resp, exp_rdata});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_hold"},
                  {cmd_ready, rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata},
                  {1'b0, 1'b1, wr, exp_to, exp_resp, exp_rdata});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_back_to_idle"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1, "[TB] bench did not terminate");
  end

  initial begin
    int a0, w0, r0, b0, acc;
    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_handshakes",
                {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                 m_axi_rready, rsp_valid, rsp_timeout}, 8'h00);
    checkOutput("reset_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrobe, rsp_resp}, 62'h0);
    areset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Single write, always-ready slave
    a0 = aw_hi; w0 = w_hi; b0 = b_hs_n;
    runTxn("wr1", 1'b1, 24'h4, 32'h5555_5555, 4'hF, 2'b01, 0, 3, 32'h0, OKAY, 1'b0);
    checkOutput("wr1_aw_cycles", 64'(aw_hi - a0), 64'd1);
    checkOutput("wr1_w_cycles", 64'(w_hi - w0), 64'd1);
    checkOutput("wr1_b_count", 64'(b_hs_n - b0), 64'd1);
    checkOutput("wr1_awaddr_prot", {aw_a, aw_p}, {24'h4, 2'b01});

    // Read back, held 4 cycles in RESP
    runTxn("rd1", 1'b0, 24'h4, 32'h0, 4'h0, 2'b00, 4, 3, 32'h5555_5555, OKAY, 1'b0);
    checkOutput("rd1_araddr", 64'(ar_a), 64'h4);

    // W channel stalled five cycles behind AW
    w_delay = 5;
    a0 = aw_hi; w0 = w_hi; b0 = b_hs_n;
    runTxn("wr2", 1'b1, 24'h100, 32'h1234_5678, 4'hF, 2'b00, 0, 8, 32'h0, OKAY, 1'b0);
    checkOutput("wr2_aw_cycles", 64'(aw_hi - a0), 64'd1);
    checkOutput("wr2_w_cycles", 64'(w_hi - w0), 64'd6);
    checkOutput("wr2_b_count", 64'(b_hs_n - b0), 64'd1);
    checkOutput("wr2_wdata", 64'(w_d), 64'h1234_5678);
    w_delay = 0;

    // Slave error responses pass through; partial strobe lands two bytes
    bresp_cfg = DECERR;
    runTxn("wr_err", 1'b1, 24'h8, 32'hA5A5_A5A5, 4'h3, 2'b00, 0, 3, 32'h0, DECERR, 1'b0);
    bresp_cfg = OKAY;
    rresp_cfg = SLVERR;
    runTxn("rd_err", 1'b0, 24'h8, 32'h0, 4'h0, 2'b00, 0, 3, 32'h0000_A5A5, SLVERR, 1'b0);
    rresp_cfg = OKAY;

    // AR never accepted: watchdog gives up after eight cycles
    ar_hang = 1'b1;
    r0 = ar_hi;
    runTxn("rd_to", 1'b0, 24'h20, 32'h0, 4'h0, 2'b00, 0, 9, 32'h0, SLVERR, 1'b1);
    checkOutput("rd_to_ar_cycles", 64'(ar_hi - r0), 64'd8);
    ar_hang = 1'b0;
    runTxn("rd_after_to", 1'b0, 24'h4, 32'h0, 4'h0, 2'b00, 0, 3, 32'h5555_5555, OKAY, 1'b0);

    // Reset while waiting in WRESP
    b_hang = 1'b1;
    applyStimulus(1'b1, 24'h40, 32'hDEAD_BEEF, 4'hF, 2'b10, acc);
    repeat (2) @(negedge clk);
    checkOutput("wresp_waiting", {m_axi_bready, m_axi_awvalid, m_axi_wvalid, rsp_valid}, 4'b1000);
    areset = 1'b1;
    b_hang = 1'b0;
    @(negedge clk);
    checkOutput("midreset_handshakes",
                {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                 m_axi_rready, rsp_valid, rsp_timeout, rsp_write}, 9'h000);
    checkOutput("midreset_payload",
                {m_axi_awaddr, m_axi_awprot, m_axi_wdata, m_axi_wstrobe}, 62'h0);
    areset = 1'b0;
    @(negedge clk);
    checkOutput("postreset_idle", {cmd_ready, m_axi_bready, rsp_valid}, 3'b100);
    runTxn("rd_post_reset", 1'b0, 24'h100, 32'h0, 4'h0, 2'b00, 0, 3, 32'h1234_5678, OKAY, 1'b0);

    checkOutput("rready_before_ar", 64'(rready_early), 64'd0);
    checkOutput("payload_stability", 64'(stab_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
